// File: rtl/spi_lcd_frame_ctrl.sv
// spi_lcd_frame_ctrl: frames SPI bytes into LCD commands, queues character writes, reports status.
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   ssel                   SPI chip select (active low); high marks a frame boundary
//   rx_valid, rx_byte      received byte level-valid and data from the SPI slave
//   tx_byte                status byte shifted back on MISO
//   lcd_wr_valid/ready     handshake for the LCD buffer write port
//   lcd_wr_addr/data       head-of-FIFO address and character
//   busy                   clear engine armed/active or FIFO non-empty
module spi_lcd_frame_ctrl #(
   parameter int          ADDR_W   = 5,
   parameter int          FIFO_AW  = 2,
   parameter logic [7:0]  CLR_CHAR = 8'h20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ssel,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic [7:0]        tx_byte,
   output logic              lcd_wr_valid,
   input  logic              lcd_wr_ready,
   output logic [ADDR_W-1:0] lcd_wr_addr,
   output logic [7:0]        lcd_wr_data,
   output logic              busy
);
   localparam int DEPTH = 1 << FIFO_AW;
   typedef enum logic [1:0] {IDLE, ADDR, DATA, DISCARD} state_t;
   state_t state, state_n;
   logic rx_valid_q, synced, rx_stb, cmd_stb, data_req;
   logic [ADDR_W-1:0] wr_ptr, clr_addr;
   logic clr_arm, clr_act, ovf, bad, stat_rd, sticky_clr;
   logic [ADDR_W+7:0] mem [DEPTH];
   logic [ADDR_W+7:0] push_word;
   logic [FIFO_AW-1:0] rd_idx, wr_idx;
   logic [FIFO_AW:0] count;
   logic [3:0] cnt4;
   logic empty, full, pop, push, clr_push, drop;
   // synced blocks byte strobes after a mid-frame reset until ssel has been seen high
   assign rx_stb     = rx_valid & ~rx_valid_q & ~ssel & synced;
   assign cmd_stb    = rx_stb & (state == IDLE);
   assign data_req   = rx_stb & (state == DATA);
   assign empty      = count == '0;
   assign full       = count == (FIFO_AW+1)'(DEPTH);
   assign pop        = ~empty & lcd_wr_ready;
   assign clr_push   = clr_act & ~full;
   // data bytes lose to a pending/active clear and to a full FIFO (pre-pop count)
   assign drop       = data_req & (clr_arm | clr_act | full);
   assign push       = clr_push | (data_req & ~drop);
   assign push_word  = clr_act ? {clr_addr, CLR_CHAR} : {wr_ptr, rx_byte};
   assign sticky_clr = ssel & stat_rd;
   assign cnt4       = 4'(count);
   assign lcd_wr_valid = ~empty;
   assign {lcd_wr_addr, lcd_wr_data} = empty ? '0 : mem[rd_idx];
   assign busy       = clr_arm | clr_act | ~empty;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end
   always_comb begin
      state_n = state;
      if (ssel)
         state_n = IDLE;
      else if (rx_stb)
         case (state)
            IDLE:    state_n = (rx_byte == 8'h01) ? ADDR : DISCARD;
            ADDR:    state_n = DATA;
            default: state_n = state;
         endcase
   end
   always_ff @(posedge clk) begin
      rx_valid_q <= rx_valid;
      if (!rst_n) begin
         synced   <= ssel;
         wr_ptr   <= '0;
         clr_addr <= '0;
         clr_arm  <= 1'b0;
         clr_act  <= 1'b0;
         ovf      <= 1'b0;
         bad      <= 1'b0;
         stat_rd  <= 1'b0;
         rd_idx   <= '0;
         wr_idx   <= '0;
         count    <= '0;
         tx_byte  <= '0;
      end else begin
         synced <= synced | ssel;
         if (push) begin
            mem[wr_idx] <= push_word;
            wr_idx      <= wr_idx + FIFO_AW'(1);
         end
         if (pop) rd_idx <= rd_idx + FIFO_AW'(1);
         count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
         if (rx_stb && state == ADDR) wr_ptr <= rx_byte[ADDR_W-1:0];
         else if (data_req)          wr_ptr <= wr_ptr + ADDR_W'(1);
         if (clr_push) begin
            clr_act  <= clr_addr != '1;
            clr_addr <= clr_addr + ADDR_W'(1);
         end
         if (clr_arm && empty && !clr_act) begin
            clr_arm  <= 1'b0;
            clr_act  <= 1'b1;
            clr_addr <= '0;
         end
         // a CLEAR during an active sweep restarts it in place rather than re-arming
         if (cmd_stb && rx_byte == 8'h02) begin
            if (clr_act) begin
               clr_addr <= '0;
               clr_act  <= 1'b1;
            end else
               clr_arm <= 1'b1;
         end
         ovf     <= (ovf & ~sticky_clr) | drop;
         bad     <= (bad & ~sticky_clr) | (cmd_stb & (rx_byte == 8'h00 || rx_byte > 8'h03));
         stat_rd <= (stat_rd & ~sticky_clr) | (cmd_stb & rx_byte == 8'h03);
         tx_byte <= {clr_arm | clr_act, ovf, bad, full, cnt4};
      end
   end
endmodule
